eeprom_arb: RTL
===============

// Module: eeprom_arb
// PURPOSE
//  Sequencer/arbiter in front of the EEPROM shift engine. After reset it autoloads
//  LOAD_WORDS words into shadow registers (MAC address etc.), then serves host word
//  reads one at a time. Sits between the EERD register path and the engine.
//  Never starts a transfer while software owns the bit-bang (EECD) path.
// PARAMETERS
//  ADDR_W      8        EEPROM word-address width
//  LOAD_WORDS  3        words 0..LOAD_WORDS-1 captured into shadow regs at reset
//  TIMEOUT     4096     max cycles from eng_start to eng_done before abort
// PORTS
//  s_clk       in   1              clock
//  s_resetn    in   1              synchronous active-low reset
//  h_valid     in   1              host read request
//  h_ready     out  1              request accepted (1-cycle, with h_valid)
//  h_addr      in   ADDR_W         host word address
//  h_rvalid    out  1              1-cycle response pulse
//  h_rdata     out  16             read word, valid with h_rvalid
//  h_err       out  1              timeout on this response, valid with h_rvalid
//  eecd_busy   in   1              software bit-bang active; block new starts
//  eng_start   out  1              1-cycle start pulse to engine
//  eng_addr    out  ADDR_W         word address, stable from eng_start to eng_done
//  eng_busy    in   1              engine busy
//  eng_done    in   1              1-cycle completion pulse
//  eng_rdata   in   16             engine data, valid with eng_done
//  load_data   out  16*LOAD_WORDS  shadow words, word0 in [15:0]
//  load_done   out  1              autoload finished (sticky until reset)
//  load_err    out  1              autoload timeout or checksum failure (sticky)
// BEHAVIOUR
//  Reset: all outputs 0; state LD_ISSUE; ld_idx=0; load_data=0.
//  States: LD_ISSUE, LD_WAIT, IDLE, H_WAIT, H_RESP.
//   LD_ISSUE: when !eng_busy && !eecd_busy -> eng_start=1, eng_addr=ld_idx -> LD_WAIT.
//   LD_WAIT: on eng_done store word (idx<LOAD_WORDS) -> ld_idx+1; last word ->
//            load_done=1 -> IDLE; else -> LD_ISSUE. Timeout -> load_err=1,
//            load_done=1 -> IDLE (remaining shadow words stay 0).
//   IDLE: h_valid && !eecd_busy && !eng_busy -> h_ready=1, eng_start=1,
//         eng_addr=h_addr (registered) -> H_WAIT. h_ready never 1 before load_done.
//   H_WAIT: eng_done -> capture eng_rdata -> H_RESP; timeout -> h_rdata=0,h_err=1 -> H_RESP.
//   H_RESP: h_rvalid=1 for exactly one cycle -> IDLE. No back-pressure on response.
//  Timeout counter: cleared at each eng_start, counts in *_WAIT, fires at TIMEOUT-1.
//  eng_done outside *_WAIT ignored (late done after timeout is dropped).
//  eecd_busy rising mid-transfer: current transfer completes; only new starts blocked.
//  Latency: host request to h_rvalid = engine time + 2 cycles.
//  Reset mid-transfer: state returns to LD_ISSUE; autoload restarts from word 0.
// CONFIGURATION
//  EEPROM_ARB_CSUM_EN defined: autoload reads words 0..63 (stores only first
//   LOAD_WORDS); 16-bit wrapping sum of all 64 must equal 16'hBABA, else load_err=1
//   with load_done. Undefined: autoload reads LOAD_WORDS words only; no checksum;
//   load_err only from timeout.
// STRUCTURE
//  eeprom_pkg: state enum, CSUM_WORDS=64, CSUM_VALUE=16'hBABA, EE_WORD_W=16.
//  Sub-module eeprom_csum_acc (clear/add/ok) instantiated only under EEPROM_ARB_CSUM_EN.
// TESTING
//  1 Reset release, engine model returns 16'h1100+addr, 8-cycle latency -> 3 starts
//    addr 0,1,2; load_data=48'h1102_1101_1100; load_done=1, load_err=0.
//  2 h_valid at reset release, h_addr=8'h0A -> h_ready held 0 until load_done; then
//    h_rvalid one cycle, h_rdata=16'h110A, h_err=0.
//  3 eecd_busy=1 for 50 cycles in IDLE with h_valid -> no eng_start; start on cycle
//    after eecd_busy falls.
//  4 Engine never asserts eng_done on host read (TIMEOUT=16) -> h_rvalid at start+17,
//    h_err=1, h_rdata=0; stray eng_done later ignored.
//  5 CSUM_EN, words 0..62=0, word63=16'hBABA -> load_err=0; word63=16'hBABB -> load_err=1.
//  6 s_resetn low during LD_WAIT of word 1 -> outputs 0; reload restarts at addr 0.

Source files
------------

// File: rtl/eeprom_pkg.sv
// Shared types and constants for the EEPROM autoload/host-read arbiter.
// Optional checksum autoload is selected with EEPROM_ARB_CSUM_EN.
package eeprom_pkg;

  localparam int unsigned EE_WORD_W  = 16;
  localparam int unsigned CSUM_WORDS = 64;
  localparam logic [EE_WORD_W-1:0] CSUM_VALUE = 16'hBABA;

  typedef enum logic [2:0] {
    LD_ISSUE = 3'd0,
    LD_WAIT  = 3'd1,
    IDLE     = 3'd2,
    H_WAIT   = 3'd3,
    H_RESP   = 3'd4
  } arb_state_e;

  // Host read response payload
  typedef struct packed {
    logic                 err;
    logic [EE_WORD_W-1:0] data;
  } ee_rsp_t;

endpackage

// File: rtl/eeprom_csum_acc.sv
// 16-bit wrapping checksum accumulator over the autoloaded image.
// Only instantiated when EEPROM_ARB_CSUM_EN is defined.
module eeprom_csum_acc
  import eeprom_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 add_i,
  input  logic [EE_WORD_W-1:0] data_i,
  output logic                 ok_c_o
);

  logic [EE_WORD_W-1:0] sum_q, sum_d;

  // Running sum; clear wins over add
  always_comb begin
    sum_d = sum_q;
    if (clear_i) begin
      sum_d = '0;
    end else if (add_i) begin
      sum_d = sum_q + data_i;
    end
  end

  // Sum register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  // True when the sum including the word on data_i hits the signature
  assign ok_c_o = ((sum_q + data_i) == CSUM_VALUE);

endmodule

// File: rtl/eeprom_arb.sv
// EEPROM sequencer/arbiter: autoloads shadow words after reset, then serves
// single host word reads through the shift engine. Blocks new engine starts
// while the software bit-bang path is active.
// Build option: EEPROM_ARB_CSUM_EN reads a full 64-word image at autoload and
// flags load_err unless its 16-bit wrapping sum equals CSUM_VALUE.
module eeprom_arb
  import eeprom_pkg::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned LOAD_WORDS = 3,
  parameter int unsigned TIMEOUT    = 4096
) (
  input  logic                            s_clk,
  input  logic                            s_resetn,
  input  logic                            h_valid,
  output logic                            h_ready,
  input  logic [ADDR_W-1:0]               h_addr,
  output logic                            h_rvalid,
  output logic [EE_WORD_W-1:0]            h_rdata,
  output logic                            h_err,
  input  logic                            eecd_busy,
  output logic                            eng_start,
  output logic [ADDR_W-1:0]               eng_addr,
  input  logic                            eng_busy,
  input  logic                            eng_done,
  input  logic [EE_WORD_W-1:0]            eng_rdata,
  output logic [EE_WORD_W*LOAD_WORDS-1:0] load_data,
  output logic                            load_done,
  output logic                            load_err
);

`ifdef EEPROM_ARB_CSUM_EN
  localparam int unsigned LD_COUNT = CSUM_WORDS;
`else
  localparam int unsigned LD_COUNT = LOAD_WORDS;
`endif
  localparam int unsigned LD_IDX_W = $clog2(LD_COUNT + 1);
  localparam int unsigned TO_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned LD_W     = EE_WORD_W * LOAD_WORDS;

  arb_state_e            state_q, state_d;
  logic [LD_IDX_W-1:0]   ld_idx_q, ld_idx_d;
  logic [TO_W-1:0]       tcnt_q, tcnt_d;
  logic                  eng_start_q, eng_start_d;
  logic [ADDR_W-1:0]     eng_addr_q, eng_addr_d;
  logic                  h_ready_q, h_ready_d;
  logic                  h_rvalid_q, h_rvalid_d;
  ee_rsp_t               rsp_q, rsp_d;
  logic [LD_W-1:0]       load_data_q, load_data_d;
  logic                  load_done_q, load_done_d;
  logic                  load_err_q, load_err_d;
  logic                  timeout_c;
  logic                  last_word_c;
  logic                  csum_clear_c;
  logic                  csum_add_c;

  assign timeout_c   = (tcnt_q == TO_W'(TIMEOUT - 1));
  assign last_word_c = (ld_idx_q == LD_IDX_W'(LD_COUNT - 1));

`ifdef EEPROM_ARB_CSUM_EN
  logic csum_ok_c;

  // Checksum over every autoloaded word
  eeprom_csum_acc u_csum (
    .clk_i   (s_clk),
    .rst_ni  (s_resetn),
    .clear_i (csum_clear_c),
    .add_i   (csum_add_c),
    .data_i  (eng_rdata),
    .ok_c_o  (csum_ok_c)
  );
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    ld_idx_d     = ld_idx_q;
    tcnt_d       = tcnt_q;
    eng_start_d  = 1'b0;
    eng_addr_d   = eng_addr_q;
    h_ready_d    = 1'b0;
    h_rvalid_d   = 1'b0;
    rsp_d        = rsp_q;
    load_data_d  = load_data_q;
    load_done_d  = load_done_q;
    load_err_d   = load_err_q;
    csum_clear_c = 1'b0;
    csum_add_c   = 1'b0;

    unique case (state_q)
      LD_ISSUE: begin
        csum_clear_c = (ld_idx_q == '0);
        if (!eng_busy && !eecd_busy) begin
          eng_start_d = 1'b1;
          eng_addr_d  = ADDR_W'(ld_idx_q);
          tcnt_d      = '0;
          state_d     = LD_WAIT;
        end
      end

      LD_WAIT: begin
        if (eng_done) begin
          csum_add_c = 1'b1;
          for (int unsigned i = 0; i < LOAD_WORDS; i++) begin
            if (ld_idx_q == LD_IDX_W'(i)) begin
              load_data_d[i*EE_WORD_W +: EE_WORD_W] = eng_rdata;
            end
          end
          ld_idx_d = ld_idx_q + 1'b1;
          if (last_word_c) begin
            load_done_d = 1'b1;
`ifdef EEPROM_ARB_CSUM_EN
            load_err_d  = !csum_ok_c;
`endif
            state_d     = IDLE;
          end else begin
            state_d = LD_ISSUE;
          end
        end else if (timeout_c) begin
          load_err_d  = 1'b1;
          load_done_d = 1'b1;
          state_d     = IDLE;
        end else begin
          // Counter restarts on the start-pulse cycle itself
          tcnt_d = eng_start_q ? '0 : tcnt_q + 1'b1;
        end
      end

      IDLE: begin
        if (h_valid && !eecd_busy && !eng_busy) begin
          h_ready_d   = 1'b1;
          eng_start_d = 1'b1;
          eng_addr_d  = h_addr;
          tcnt_d      = '0;
          state_d     = H_WAIT;
        end
      end

      H_WAIT: begin
        if (eng_done) begin
          rsp_d      = '{err: 1'b0, data: eng_rdata};
          h_rvalid_d = 1'b1;
          state_d    = H_RESP;
        end else if (timeout_c) begin
          rsp_d      = '{err: 1'b1, data: '0};
          h_rvalid_d = 1'b1;
          state_d    = H_RESP;
        end else begin
          tcnt_d = eng_start_q ? '0 : tcnt_q + 1'b1;
        end
      end

      H_RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = LD_ISSUE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge s_clk) begin
    if (!s_resetn) begin
      state_q     <= LD_ISSUE;
      ld_idx_q    <= '0;
      tcnt_q      <= '0;
      eng_start_q <= 1'b0;
      eng_addr_q  <= '0;
      h_ready_q   <= 1'b0;
      h_rvalid_q  <= 1'b0;
      rsp_q       <= '0;
      load_data_q <= '0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ld_idx_q    <= ld_idx_d;
      tcnt_q      <= tcnt_d;
      eng_start_q <= eng_start_d;
      eng_addr_q  <= eng_addr_d;
      h_ready_q   <= h_ready_d;
      h_rvalid_q  <= h_rvalid_d;
      rsp_q       <= rsp_d;
      load_data_q <= load_data_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
    end
  end

  assign h_ready   = h_ready_q;
  assign h_rvalid  = h_rvalid_q;
  assign h_rdata   = rsp_q.data;
  assign h_err     = rsp_q.err;
  assign eng_start = eng_start_q;
  assign eng_addr  = eng_addr_q;
  assign load_data = load_data_q;
  assign load_done = load_done_q;
  assign load_err  = load_err_q;

endmodule
